// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Groups the display-data input bus and the LED-driver outputs of
// seg_scan_driver.
//   data       32  word to display, nibble i -> digit i (digit 0 rightmost)
//   load        1  sample strobe for data
//   blank_lz    1  leading-zero blanking enable
//   dp_mask     8  per-digit decimal point enable (1 = lit)
//   AN          8  anode enables, active-low
//   SEG         8  segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_done  1  one-cycle pulse after each 8-digit frame
// master = data source / observer, slave = the scan driver.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
  logic [31:0] data;
  logic        load;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_done;

  modport master (
    output data, load, blank_lz, dp_mask,
    input  AN, SEG, frame_done
  );

  modport slave (
    input  data, load, blank_lz, dp_mask,
    output AN, SEG, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed 8-digit seven-segment scan driver.
//   clk   board clock
//   rst   asynchronous active-low reset
//   bus   seg_scan_driver_if.slave (data/load/blank_lz/dp_mask in,
//         AN/SEG/frame_done out)
// Each digit owns SCAN_DIV clocks; the first GAP clocks of a slot keep all
// anodes off to avoid ghosting. A loaded word is held pending and only moved
// into the displayed (shadow) word at the frame boundary, so one frame never
// mixes two words. All outputs are registered and reflect the state of the
// previous cycle.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP      = 2000
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_driver_if.slave    bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_C   = CW'(GAP);

  typedef enum logic {DEAD, LIT} phase_t;

  // With GAP == 0 there is no dead time, so cnt == 0 is already lit.
  localparam phase_t RST_PHASE = (GAP == 0) ? LIT : DEAD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          pend_q, pend_d;
  phase_t        phase_q, phase_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic          boundary;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic [7:0]    lz;
  logic          blank;

  // lz[i] = nibbles i..7 of the shadow word are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lz
      assign lz[gi] = (shadow_q[31:4*gi] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      pend_data_q <= '0;
      pend_q      <= 1'b0;
      phase_q     <= RST_PHASE;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    wrap        = (cnt_q == CNT_MAX);
    boundary    = wrap && (idx_q == 3'd7);
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    idx_d       = wrap ? idx_q + 3'd1 : idx_q;
    // phase_q always describes the current cnt_q, so it is derived from cnt_d.
    phase_d     = (cnt_d < GAP_C) ? DEAD : LIT;

    shadow_d    = shadow_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    if (bus.load) begin
      pend_data_d = bus.data;
      pend_d      = 1'b1;
    end
    if (boundary) begin
      // A load on the boundary cycle itself bypasses the pending register.
      if (bus.load)   shadow_d = bus.data;
      else if (pend_q) shadow_d = pend_data_q;
      pend_d = 1'b0;
    end

    nib = shadow_q[4*idx_q +: 4];
    case (nib)
      4'h0:    dec = 7'h40;
      4'h1:    dec = 7'h79;
      4'h2:    dec = 7'h24;
      4'h3:    dec = 7'h30;
      4'h4:    dec = 7'h19;
      4'h5:    dec = 7'h12;
      4'h6:    dec = 7'h02;
      4'h7:    dec = 7'h78;
      4'h8:    dec = 7'h00;
      4'h9:    dec = 7'h10;
      4'hA:    dec = 7'h08;
      4'hB:    dec = 7'h03;
      4'hC:    dec = 7'h46;
      4'hD:    dec = 7'h21;
      4'hE:    dec = 7'h06;
      default: dec = 7'h0E;
    endcase
    blank = bus.blank_lz && (idx_q != 3'd0) && lz[idx_q];

    an_d  = 8'hFF;
    seg_d = 8'hFF;
    unique case (phase_q)
      DEAD: ;
      LIT: begin
        an_d  = ~(8'h01 << idx_q);
        seg_d = {~bus.dp_mask[idx_q], blank ? 7'h7F : dec};
      end
    endcase
    fd_d = boundary;
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.frame_done = fd_q;

endmodule
